limit_counter_ctl: RTL and testbench
====================================

Name: limit_counter_ctl

Overview:
- Parametrised terminal-count controller: counts prescaled ticks from 0 up to a runtime limit `n`.
- Supports one-shot, auto-reload and up/down bounce modes.
- Flags a sticky `limit` level and a one-cycle `tc_pulse` at each terminal event.
- Used as the general sequencing and timeout counter in the datapath; the WIDTH-generalised successor of the 8-bit count-to-n counter.

Parameters:
- WIDTH, 8, width of `n` and `count`.
- PRE_W, 4, width of the prescale divider field.

Ports:
- mclk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high; highest priority.
- sreset  in  1  synchronous, active-high soft clear; same effect as `reset`, lower priority.
- start  in  1  latch `n`/`mode`/`prescale`, clear count, enter RUN.
- stop  in  1  RUN -> IDLE; `count` is held.
- en  in  1  prescaler enable; low freezes the prescaler and count.
- n  in  WIDTH  terminal value; sampled only on `start`.
- mode  in  2  00 one-shot, 01 auto-reload, 10 bounce, 11 treated as 00.
- prescale  in  PRE_W  tick every prescale+1 enabled cycles.
- count  out  WIDTH  current count.
- limit  out  1  mode 00: sticky terminal flag; modes 01/10: high while count == n_lat.
- tc_pulse  out  1  one-cycle terminal event.
- busy  out  1  high in RUN.
- dir  out  1  0 = counting up, 1 = counting down (bounce only).

Behaviour:
- Reset state: `count`=0, `limit`=0, `tc_pulse`=0, `busy`=0, `dir`=0, `pre_cnt`=0, state IDLE, latches `n_lat`/`mode_lat`/`pre_lat`=0.
- Priority per edge: `reset` > `sreset` > `start` > `stop` > tick.
- FSM states:
  - IDLE, `busy`=0: `start` -> RUN.
  - RUN, `busy`=1: `stop` -> IDLE; one-shot terminal -> DONE.
  - DONE, `busy`=0, `limit` held: `start` -> RUN.
- `start` in any state:
  - latches `n_lat`, `mode_lat`, `pre_lat`;
  - sets `count`=0, `pre_cnt`=0, `dir`=0, `limit`=0;
  - enters RUN. Restart mid-run is legal and discards progress.
- Prescaler (RUN only):
  - tick when `en` && `pre_cnt` == `pre_lat`; `pre_cnt` -> 0 on tick, else +1 while `en`.
  - `en`=0 holds `pre_cnt` and `count`.
- Latency: `start` sampled at edge k -> `count`=0 and `busy`=1 after edge k. With `pre_lat`=0 and `en`=1, `count`=1 after edge k+1.
- Up tick, mode 00:
  - if `count` >= `n_lat`: terminal, no increment;
  - else `count`+1, and terminal in the same edge when `count`+1 == `n_lat`.
  - Terminal: `tc_pulse`=1 for one cycle, `limit`=1 sticky, state -> DONE, `count` frozen at `n_lat`.
- Mode 01:
  - count 0..n_lat; `tc_pulse` on the edge `count` becomes `n_lat`;
  - next tick `count` -> 0 and counting continues;
  - no DONE state.
- Mode 10:
  - up to `n_lat` (`tc_pulse`, `dir` -> 1), then down to 0 (`tc_pulse`, `dir` -> 0), repeat;
  - endpoints are each held for exactly one tick period.
- `n_lat`=0:
  - mode 00: first tick is terminal;
  - modes 01/10: `count` stays 0 and `tc_pulse` fires every tick.
- Arithmetic: unsigned WIDTH bits. `count` never exceeds `n_lat` and never wraps through 2^WIDTH; the maximum `n` = 2^WIDTH-1 is reachable.
- `tc_pulse` is never high for two consecutive cycles unless `pre_lat`=0 and the terminal condition recurs on every tick.
- `stop` and tick on the same edge: `stop` wins, no count change. `stop` outside RUN is ignored.
- `reset`/`sreset` mid-run: immediate return to reset state. No pulse is generated.

Test Plan:
- WIDTH=8, mode 00, n=5, prescale=0, en=1, start pulse -> `count` 0,1,2,3,4,5 on consecutive edges; `tc_pulse` high only with `count`=5; `limit`=1 held, `busy`=0 until `start`.
- Mode 01, n=3, prescale=2 -> `count` changes every 3 cycles: 0,1,2,3,0,1...; `tc_pulse` once per entry to 3; `limit` high only while `count`=3.
- Mode 10, n=2 -> `count` 0,1,2,1,0,1,2...; `dir` toggles at 2 and 0; `tc_pulse` at each endpoint.
- n=0 in each mode, and n=255 with WIDTH=8 in mode 00:
  - mode 00, n=0: terminal on the first tick;
  - n=255: terminal at 255, no wrap to 0.
- Mode 00, n=10:
  - `en` toggled every other cycle -> count advances only on enabled ticks;
  - `stop` at count=4 -> `count` holds 4, `busy`=0;
  - `start` -> restarts at 0.
- `sreset` asserted at count=7 in mode 01, coincident with `start` -> reset state wins: all outputs 0, IDLE. `reset` during DONE clears `limit`.

Source files
------------

// File: rtl/limit_counter_ctl_if.sv
// Control/status bundle for the terminal-count controller.
// The bench or sequencer drives it through the master modport; the counter uses the slave modport.
interface limit_counter_ctl_if #(
   parameter int WIDTH = 8,
   parameter int PRE_W = 4
);
   logic             start;
   logic             stop;
   logic             en;
   logic [WIDTH-1:0] n;
   logic [1:0]       mode;
   logic [PRE_W-1:0] prescale;
   logic [WIDTH-1:0] count;
   logic             limit;
   logic             tc_pulse;
   logic             busy;
   logic             dir;

   modport master (
      output start, stop, en, n, mode, prescale,
      input  count, limit, tc_pulse, busy, dir
   );

   modport slave (
      input  start, stop, en, n, mode, prescale,
      output count, limit, tc_pulse, busy, dir
   );
endinterface

// File: rtl/limit_counter_ctl.sv
// Prescaled terminal-count controller with one-shot, auto-reload and bounce modes.
// It reports a limit level, a one-cycle terminal pulse, a busy flag and the count direction.
module limit_counter_ctl #(
   parameter int WIDTH = 8,
   parameter int PRE_W = 4
) (
   input  logic                 mclk,
   input  logic                 reset,
   input  logic                 sreset,
   limit_counter_ctl_if.slave   bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] count, count_nx;
   logic [WIDTH-1:0] n_lat, n_lat_nx;
   logic [1:0]       mode_lat, mode_lat_nx;
   logic [PRE_W-1:0] pre_lat, pre_lat_nx;
   logic [PRE_W-1:0] pre_cnt, pre_cnt_nx;
   logic             dir, dir_nx;
   logic             limit, limit_nx;
   logic             tc, tc_nx;

   always_ff @(posedge mclk) begin
      if (reset || sreset) begin
         state    <= IDLE;
         count    <= '0;
         n_lat    <= '0;
         mode_lat <= '0;
         pre_lat  <= '0;
         pre_cnt  <= '0;
         dir      <= 1'b0;
         limit    <= 1'b0;
         tc       <= 1'b0;
      end else begin
         state    <= state_nx;
         count    <= count_nx;
         n_lat    <= n_lat_nx;
         mode_lat <= mode_lat_nx;
         pre_lat  <= pre_lat_nx;
         pre_cnt  <= pre_cnt_nx;
         dir      <= dir_nx;
         limit    <= limit_nx;
         tc       <= tc_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      count_nx    = count;
      n_lat_nx    = n_lat;
      mode_lat_nx = mode_lat;
      pre_lat_nx  = pre_lat;
      pre_cnt_nx  = pre_cnt;
      dir_nx      = dir;
      limit_nx    = limit;
      tc_nx       = 1'b0;

      if (bus.start) begin
         n_lat_nx    = bus.n;
         mode_lat_nx = bus.mode;
         pre_lat_nx  = bus.prescale;
         count_nx    = '0;
         pre_cnt_nx  = '0;
         dir_nx      = 1'b0;
         limit_nx    = 1'b0;
         state_nx    = RUN;
      end else if (bus.stop && state == RUN) begin
         state_nx = IDLE;
      end else if (state == RUN && bus.en) begin
         if (pre_cnt != pre_lat) begin
            pre_cnt_nx = pre_cnt + PRE_W'(1);
         end else begin
            pre_cnt_nx = '0;
            case (mode_lat)
               2'b01: begin
                  count_nx = (count == n_lat) ? '0 : count + WIDTH'(1);
                  tc_nx    = (count_nx == n_lat);
                  limit_nx = tc_nx;
               end
               2'b10: begin
                  // Each endpoint is left on the tick after it was reached, so it is shown for one period.
                  if (n_lat == '0) begin
                     count_nx = '0;
                     tc_nx    = 1'b1;
                  end else if (!dir) begin
                     count_nx = count + WIDTH'(1);
                     if (count_nx == n_lat) begin
                        tc_nx  = 1'b1;
                        dir_nx = 1'b1;
                     end
                  end else begin
                     count_nx = count - WIDTH'(1);
                     if (count_nx == '0) begin
                        tc_nx  = 1'b1;
                        dir_nx = 1'b0;
                     end
                  end
                  limit_nx = (count_nx == n_lat);
               end
               default: begin
                  // Mode 11 shares the one-shot path; the >= test makes n_lat=0 terminate on the first tick.
                  if (count >= n_lat) begin
                     count_nx = n_lat;
                     tc_nx    = 1'b1;
                     limit_nx = 1'b1;
                     state_nx = DONE;
                  end else begin
                     count_nx = count + WIDTH'(1);
                     if (count_nx == n_lat) begin
                        tc_nx    = 1'b1;
                        limit_nx = 1'b1;
                        state_nx = DONE;
                     end
                  end
               end
            endcase
         end
      end
   end

   assign bus.count    = count;
   assign bus.limit    = limit;
   assign bus.tc_pulse = tc;
   assign bus.busy     = (state == RUN);
   assign bus.dir      = dir;
endmodule

// File: tb/tb_limit_counter_ctl.sv
// Bench for limit_counter_ctl: a tick-count reference model is compared on every cycle.
// Directed literal checks pin that model for the main sequences and the edge cases.
module tb_limit_counter_ctl;
   logic mclk;
   logic reset;
   logic sreset;
   logic chk_en;
   int   total;
   int   bad;

   limit_counter_ctl_if #(.WIDTH(8), .PRE_W(4)) bus();

   limit_counter_ctl #(.WIDTH(8), .PRE_W(4)) dut (
      .mclk   (mclk),
      .reset  (reset),
      .sreset (sreset),
      .bus    (bus)
   );

   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   // Reference model: count is derived from the number of ticks since start.
   int m_phase;  // 0 idle, 1 run, 2 done
   int m_t, m_pre, m_n, m_mode, m_pl, m_tc, m_term;

   always @(posedge mclk) begin
      if (reset || sreset) begin
         m_phase = 0; m_t = 0; m_pre = 0; m_n = 0; m_mode = 0; m_pl = 0;
         m_tc = 0; m_term = 0;
      end else begin
         m_tc = 0;
         if (bus.start) begin
            m_n = bus.n; m_pl = bus.prescale;
            m_mode = (bus.mode == 2'd3) ? 0 : int'(bus.mode);
            m_phase = 1; m_t = 0; m_pre = 0; m_term = 0;
         end else if (bus.stop && m_phase == 1) begin
            m_phase = 0;
         end else if (m_phase == 1 && bus.en) begin
            if (m_pre != m_pl) m_pre = m_pre + 1;
            else begin
               m_pre = 0;
               m_t = m_t + 1;
               if (m_mode == 0) begin
                  if (m_t >= ((m_n > 0) ? m_n : 1)) begin
                     m_tc = 1; m_term = 1; m_phase = 2;
                  end
               end else if (m_mode == 1) begin
                  m_tc = ((m_t % (m_n + 1)) == m_n) ? 1 : 0;
               end else begin
                  m_tc = (m_n == 0 || (m_t % m_n) == 0) ? 1 : 0;
               end
            end
         end
      end
   end

   function automatic int exp_count();
      int r;
      if (m_mode == 1) return m_t % (m_n + 1);
      if (m_mode == 2) begin
         if (m_n == 0) return 0;
         r = m_t % (2 * m_n);
         return (r <= m_n) ? r : 2 * m_n - r;
      end
      return (m_t < m_n) ? m_t : m_n;
   endfunction

   function automatic int exp_limit();
      if (m_mode == 0) return m_term;
      return (m_t > 0 && exp_count() == m_n) ? 1 : 0;
   endfunction

   function automatic int exp_dir();
      if (m_mode != 2 || m_n == 0) return 0;
      return ((m_t / m_n) % 2 == 1) ? 1 : 0;
   endfunction

   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   always @(negedge mclk) begin
      if (chk_en) begin
         check("model_count", int'(bus.count), exp_count());
         check("model_limit", int'(bus.limit), exp_limit());
         check("model_tc", int'(bus.tc_pulse), m_tc);
         check("model_busy", int'(bus.busy), (m_phase == 1) ? 1 : 0);
         check("model_dir", int'(bus.dir), exp_dir());
      end
   end

   task automatic do_start(input int nv, input int md, input int pr);
      @(negedge mclk);
      bus.start = 1'b1; bus.n = 8'(nv); bus.mode = 2'(md); bus.prescale = 4'(pr);
      @(negedge mclk);
      bus.start = 1'b0;
   endtask

   int exp01[5] = '{1, 2, 3, 0, 1};
   int exp10[6] = '{1, 2, 1, 0, 1, 2};
   int dir10[6] = '{0, 1, 1, 0, 0, 1};
   int tc10[6]  = '{0, 1, 0, 1, 0, 1};

   initial begin
      total = 0; bad = 0; chk_en = 1'b0;
      reset = 1'b1; sreset = 1'b0;
      bus.start = 1'b0; bus.stop = 1'b0; bus.en = 1'b1;
      bus.n = '0; bus.mode = '0; bus.prescale = '0;
      @(negedge mclk);
      @(negedge mclk);
      chk_en = 1'b1;
      check("rst_count", int'(bus.count), 0);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_limit", int'(bus.limit), 0);
      reset = 1'b0;

      // One-shot, n=5
      do_start(5, 0, 0);
      check("os5_start_count", int'(bus.count), 0);
      check("os5_start_busy", int'(bus.busy), 1);
      for (int i = 1; i <= 5; i++) begin
         @(negedge mclk);
         check("os5_count", int'(bus.count), i);
         check("os5_tc", int'(bus.tc_pulse), (i == 5) ? 1 : 0);
      end
      repeat (3) @(negedge mclk);
      check("os5_hold_count", int'(bus.count), 5);
      check("os5_hold_limit", int'(bus.limit), 1);
      check("os5_hold_busy", int'(bus.busy), 0);
      check("os5_hold_tc", int'(bus.tc_pulse), 0);

      // Auto-reload, n=3, prescale=2
      do_start(3, 1, 2);
      for (int j = 0; j < 5; j++) begin
         repeat (3) @(negedge mclk);
         check("ar3_count", int'(bus.count), exp01[j]);
         check("ar3_limit", int'(bus.limit), (exp01[j] == 3) ? 1 : 0);
         check("ar3_tc", int'(bus.tc_pulse), (exp01[j] == 3) ? 1 : 0);
      end

      // Bounce, n=2
      do_start(2, 2, 0);
      for (int j = 0; j < 6; j++) begin
         @(negedge mclk);
         check("bn2_count", int'(bus.count), exp10[j]);
         check("bn2_dir", int'(bus.dir), dir10[j]);
         check("bn2_tc", int'(bus.tc_pulse), tc10[j]);
      end

      // n=0 in each mode
      do_start(0, 0, 0);
      @(negedge mclk);
      check("os0_tc", int'(bus.tc_pulse), 1);
      check("os0_busy", int'(bus.busy), 0);
      check("os0_count", int'(bus.count), 0);
      do_start(0, 1, 0);
      repeat (3) begin
         @(negedge mclk);
         check("ar0_tc", int'(bus.tc_pulse), 1);
         check("ar0_count", int'(bus.count), 0);
      end
      do_start(0, 2, 0);
      repeat (3) begin
         @(negedge mclk);
         check("bn0_tc", int'(bus.tc_pulse), 1);
         check("bn0_count", int'(bus.count), 0);
      end

      // One-shot to the full-scale limit
      do_start(255, 0, 0);
      repeat (254) @(negedge mclk);
      check("os255_pre_count", int'(bus.count), 254);
      check("os255_pre_tc", int'(bus.tc_pulse), 0);
      @(negedge mclk);
      check("os255_count", int'(bus.count), 255);
      check("os255_tc", int'(bus.tc_pulse), 1);
      repeat (2) @(negedge mclk);
      check("os255_nowrap", int'(bus.count), 255);
      check("os255_limit", int'(bus.limit), 1);

      // Gated enable, stop, restart
      do_start(10, 0, 0);
      for (int i = 0; i < 8; i++) begin
         bus.en = i[0];
         @(negedge mclk);
      end
      check("en_count", int'(bus.count), 4);
      bus.stop = 1'b1;
      @(negedge mclk);
      bus.stop = 1'b0;
      check("stop_count", int'(bus.count), 4);
      check("stop_busy", int'(bus.busy), 0);
      bus.stop = 1'b1;
      repeat (2) @(negedge mclk);
      bus.stop = 1'b0;
      check("stop_idle_count", int'(bus.count), 4);
      do_start(10, 0, 0);
      check("restart_count", int'(bus.count), 0);
      @(negedge mclk);
      check("restart_count1", int'(bus.count), 1);

      // Restart mid-run discards bounce progress
      do_start(4, 2, 0);
      repeat (5) @(negedge mclk);
      do_start(3, 1, 0);
      check("midrun_count", int'(bus.count), 0);
      check("midrun_dir", int'(bus.dir), 0);

      // Soft clear beats a coincident start
      do_start(10, 1, 0);
      repeat (7) @(negedge mclk);
      check("sr_pre_count", int'(bus.count), 7);
      sreset = 1'b1; bus.start = 1'b1; bus.n = 8'd20;
      @(negedge mclk);
      sreset = 1'b0; bus.start = 1'b0;
      check("sr_count", int'(bus.count), 0);
      check("sr_busy", int'(bus.busy), 0);
      check("sr_limit", int'(bus.limit), 0);
      check("sr_tc", int'(bus.tc_pulse), 0);
      @(negedge mclk);
      check("sr_idle_count", int'(bus.count), 0);

      // Hard reset while DONE clears the sticky limit
      do_start(1, 0, 0);
      repeat (2) @(negedge mclk);
      check("done_limit", int'(bus.limit), 1);
      reset = 1'b1;
      @(negedge mclk);
      reset = 1'b0;
      check("rst_done_limit", int'(bus.limit), 0);
      check("rst_done_count", int'(bus.count), 0);

      repeat (2) @(negedge mclk);
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
